key_checker: RTL and testbench
==============================

KEY_CHECKER -- requirements
Module: key_checker

Interface
REQ-001 Parameter LAST_ROW, default 99: index of the final row; a correct press on this row wins the game.
REQ-002 Parameter TIMEOUT_CYCLES, default 50000000: maximum clk cycles allowed per row, used only under TIMEOUT_EN.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port Reset  in  1: reset, asynchronous and active-high.
REQ-005 Port StartGame  in  1: level; start or restart the game.
REQ-006 Port array_in  in  3 x 100 (unpacked): one-hot lane code per row (3'b100 left, 3'b010 middle, 3'b001 right).
REQ-007 Port row_counter  in  7: current row index, 0..LAST_ROW.
REQ-008 Port key_in  in  3: debounced pressed-lane vector, same bit order as array_in.
REQ-009 Port correct_key  out  1: one-cycle pulse per accepted press; drives the row advance.
REQ-010 Port is_GameOver  out  1: level; high after a wrong press or a timeout.
REQ-011 Port win  out  1: level; high after LAST_ROW is cleared.
REQ-012 Port score  out  8: count of accepted presses.

Function
REQ-013 FSM states SHALL be IDLE, ARMED, HOLD, OVER and WIN; all outputs are registered.
REQ-014 Any state with StartGame=1 SHALL go to ARMED next cycle: score=0, is_GameOver=0, win=0, correct_key=0; StartGame overrides every other event in that cycle.
REQ-015 IDLE SHALL ignore key_in until StartGame.
REQ-016 ARMED with key_in=0 SHALL hold the state.
REQ-017 ARMED with key_in==array_in[row_counter] sampled at edge N SHALL drive correct_key=1 during cycle N+1 only, increment score (saturate at 255), and go to HOLD.
REQ-018 ARMED with key_in nonzero and mismatched (including multi-lane presses) SHALL go to OVER with is_GameOver=1; score is frozen.
REQ-019 HOLD SHALL wait for key_in=0, then go to ARMED; a held key SHALL NEVER produce a second correct_key pulse.
REQ-020 A press accepted on row_counter==LAST_ROW SHALL go to WIN, not HOLD: win=1 and correct_key still pulses once.
REQ-021 OVER and WIN SHALL hold their outputs until StartGame or Reset.
REQ-022 row_counter>LAST_ROW in ARMED SHALL be treated as a mismatch and go to OVER.
REQ-023 The row lookup SHALL use the row_counter value present in the sampling cycle; row_counter updates one cycle after correct_key are tolerated because HOLD lasts at least one cycle.

Reset
REQ-024 Reset=1 SHALL immediately force IDLE, correct_key=0, is_GameOver=0, win=0, score=0 and clear the timeout counter, regardless of clk.
REQ-025 Reset asserted mid-press or while in HOLD SHALL leave no pending pulse after release.

Configuration
REQ-026 Macro KEY_CHECKER_TIMEOUT_EN defined: a 32-bit counter SHALL clear on every entry to ARMED and increment each cycle in ARMED. At count TIMEOUT_CYCLES-1 with no press, the FSM SHALL go to OVER with is_GameOver=1. A press in the same cycle takes priority.
REQ-027 Macro undefined: no counter is built, and ARMED waits indefinitely; TIMEOUT_CYCLES is unused.

Verification
REQ-028 Reset, StartGame, array_in[0]=3'b010, row_counter=0, key_in=3'b010 for 1 cycle -> correct_key high exactly 1 cycle, score=1.
REQ-029 In ARMED with array_in[3]=3'b100, row_counter=3, key_in=3'b001 -> is_GameOver=1, score unchanged; later key_in=3'b100 -> no correct_key.
REQ-030 key_in=3'b010 held 20 cycles on a matching row -> exactly one correct_key; release then re-press matching next row -> second pulse, score=2.
REQ-031 row_counter=99=LAST_ROW, matching press -> correct_key pulse, win=1; StartGame -> win=0, score=0, ARMED.
REQ-032 KEY_CHECKER_TIMEOUT_EN, TIMEOUT_CYCLES=10, no press -> is_GameOver=1 after cycle 10 of ARMED; press on cycle 10 -> accepted, no game over.
REQ-033 Reset pulsed asynchronously between edges while in HOLD -> outputs zero before the next edge, state IDLE.

Source files
------------

// File: rtl/key_checker.sv
`default_nettype none
// ============================================================================
// Module   : key_checker
// Purpose  : Validates lane key presses against the per-row code of a tile
//            game. It tracks the score and flags game over or win.
//            The optional per-row timeout is built when KEY_CHECKER_TIMEOUT_EN
//            is defined.
// Revision : 1.0  initial release
// ============================================================================
module key_checker #(
    parameter int LAST_ROW       = 99,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       StartGame,
    input  logic [2:0] array_in [0:LAST_ROW],
    input  logic [6:0] row_counter,
    input  logic [2:0] key_in,
    output logic       correct_key,
    output logic       is_GameOver,
    output logic       win,
    output logic [7:0] score
);

    localparam logic [6:0] c_LAST_ROW = 7'(LAST_ROW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_HOLD  = 3'd2,
        S_OVER  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t     r_state;
    logic       w_row_valid;
    logic [2:0] w_row_code;
    logic       w_match;
    logic       w_last;

`ifdef KEY_CHECKER_TIMEOUT_EN
    localparam logic [31:0] c_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_timer;
`endif

    // Rows past the last one never match, so any press there ends the game.
    always_comb begin
        w_row_valid = (row_counter <= c_LAST_ROW);
        w_row_code  = w_row_valid ? array_in[row_counter] : 3'b000;
        w_match     = w_row_valid && (key_in == w_row_code);
        w_last      = (row_counter == c_LAST_ROW);
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            correct_key <= 1'b0;
            is_GameOver <= 1'b0;
            win         <= 1'b0;
            score       <= 8'd0;
`ifdef KEY_CHECKER_TIMEOUT_EN
            r_timer     <= 32'd0;
`endif
        end else begin
            correct_key <= 1'b0;
`ifdef KEY_CHECKER_TIMEOUT_EN
            // Counts only while ARMED is held, so every entry starts from zero.
            r_timer     <= 32'd0;
`endif
            if (StartGame) begin
                r_state     <= S_ARMED;
                is_GameOver <= 1'b0;
                win         <= 1'b0;
                score       <= 8'd0;
            end else begin
                case (r_state)
                    S_ARMED: begin
                        if (key_in != 3'b000) begin
                            if (w_match) begin
                                correct_key <= 1'b1;
                                if (score != 8'hFF) begin
                                    score <= score + 8'd1;
                                end
                                if (w_last) begin
                                    r_state <= S_WIN;
                                    win     <= 1'b1;
                                end else begin
                                    r_state <= S_HOLD;
                                end
                            end else begin
                                r_state     <= S_OVER;
                                is_GameOver <= 1'b1;
                            end
                        end
`ifdef KEY_CHECKER_TIMEOUT_EN
                        else if (r_timer == c_TIMEOUT_LAST) begin
                            r_state     <= S_OVER;
                            is_GameOver <= 1'b1;
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
`endif
                    end
                    S_HOLD: begin
                        if (key_in == 3'b000) begin
                            r_state <= S_ARMED;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_key_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_checker
// Purpose  : Directed self-checking bench for key_checker.
// Revision : 1.0  initial release
// ============================================================================
module tb_key_checker;

    logic       clk = 1'b0;
    logic       Reset;
    logic       StartGame;
    logic [2:0] array_in [0:99];
    logic [6:0] row_counter;
    logic [2:0] key_in;
    logic       correct_key;
    logic       is_GameOver;
    logic       win;
    logic [7:0] score;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses;

    key_checker #(
        .LAST_ROW      (99),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .StartGame  (StartGame),
        .array_in   (array_in),
        .row_counter(row_counter),
        .key_in     (key_in),
        .correct_key(correct_key),
        .is_GameOver(is_GameOver),
        .win        (win),
        .score      (score)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ck, input logic go,
                              input logic w, input logic [7:0] sc);
        check({tag, ".correct_key"}, {31'd0, correct_key}, {31'd0, ck});
        check({tag, ".is_GameOver"}, {31'd0, is_GameOver}, {31'd0, go});
        check({tag, ".win"},         {31'd0, win},         {31'd0, w});
        check({tag, ".score"},       {24'd0, score},       {24'd0, sc});
    endtask

    task automatic start();
        StartGame = 1'b1;
        tick();
        StartGame = 1'b0;
    endtask

    initial begin
        // Row codes cycle middle/left/right; row 3 is forced to left.
        for (int i = 0; i < 100; i++) begin
            case (i % 3)
                0:       array_in[i] = 3'b010;
                1:       array_in[i] = 3'b100;
                default: array_in[i] = 3'b001;
            endcase
        end
        array_in[3] = 3'b100;
        Reset = 1'b1; StartGame = 1'b0; row_counter = 7'd0; key_in = 3'b000;
        tick();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 8'd0);

        // IDLE ignores presses
        Reset = 1'b0; key_in = 3'b010;
        tick();
        check_outs("idle_ignore", 1'b0, 1'b0, 1'b0, 8'd0);
        key_in = 3'b000;
        start();
        check_outs("start", 1'b0, 1'b0, 1'b0, 8'd0);

        // single correct press, pulse lasts one cycle
        row_counter = 7'd0; key_in = 3'b010;
        tick();
        check_outs("press0", 1'b1, 1'b0, 1'b0, 8'd1);
        key_in = 3'b000;
        tick();
        check_outs("press0_after", 1'b0, 1'b0, 1'b0, 8'd1);

        // held key for 20 cycles gives one pulse
        row_counter = 7'd1; key_in = 3'b100; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (correct_key) pulses++;
        end
        check("held_pulses", pulses, 1);
        check("held_score", {24'd0, score}, 32'd2);
        key_in = 3'b000;
        tick();
        row_counter = 7'd2; key_in = 3'b001;
        tick();
        check_outs("repress", 1'b1, 1'b0, 1'b0, 8'd3);
        key_in = 3'b000;
        tick();

        // wrong lane on row 3
        row_counter = 7'd3; key_in = 3'b001;
        tick();
        check_outs("wrong_lane", 1'b0, 1'b1, 1'b0, 8'd3);
        key_in = 3'b000;
        tick();
        key_in = 3'b100;
        tick();
        check_outs("over_frozen", 1'b0, 1'b1, 1'b0, 8'd3);
        key_in = 3'b000;

        // multi-lane press is a mismatch
        start();
        check_outs("restart", 1'b0, 1'b0, 1'b0, 8'd0);
        row_counter = 7'd0; key_in = 3'b110;
        tick();
        check_outs("multi_lane", 1'b0, 1'b1, 1'b0, 8'd0);
        key_in = 3'b000;

        // row beyond the last row
        start();
        row_counter = 7'd100; key_in = 3'b010;
        tick();
        check_outs("row_oob", 1'b0, 1'b1, 1'b0, 8'd0);
        key_in = 3'b000;

        // last row wins
        start();
        row_counter = 7'd99; key_in = 3'b010;
        tick();
        check_outs("win_press", 1'b1, 1'b0, 1'b1, 8'd1);
        key_in = 3'b000;
        tick();
        key_in = 3'b010;
        tick();
        check_outs("win_hold", 1'b0, 1'b0, 1'b1, 8'd1);
        key_in = 3'b000;
        start();
        check_outs("win_restart", 1'b0, 1'b0, 1'b0, 8'd0);

        // StartGame outranks a matching press
        row_counter = 7'd0; key_in = 3'b010; StartGame = 1'b1;
        tick();
        StartGame = 1'b0; key_in = 3'b000;
        check_outs("start_priority", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();

        // asynchronous reset while in HOLD
        key_in = 3'b010;
        tick();
        check_outs("pre_async", 1'b1, 1'b0, 1'b0, 8'd1);
        #2 Reset = 1'b1;
        #1;
        check_outs("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        Reset = 1'b0;
        tick();
        check_outs("post_reset_held", 1'b0, 1'b0, 1'b0, 8'd0);
        key_in = 3'b000;
        tick();
        key_in = 3'b010;
        tick();
        check_outs("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        key_in = 3'b000;

        // score saturates at 255
        start();
        row_counter = 7'd0;
        for (int i = 0; i < 260; i++) begin
            key_in = 3'b010;
            tick();
            key_in = 3'b000;
            tick();
        end
        check_outs("saturate", 1'b0, 1'b0, 1'b0, 8'd255);

`ifdef KEY_CHECKER_TIMEOUT_EN
        start();
        for (int i = 0; i < 9; i++) tick();
        check_outs("timeout_before", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check_outs("timeout_fire", 1'b0, 1'b1, 1'b0, 8'd0);
        start();
        for (int i = 0; i < 9; i++) tick();
        key_in = 3'b010;
        tick();
        check_outs("timeout_press", 1'b1, 1'b0, 1'b0, 8'd1);
        key_in = 3'b000;
`else
        start();
        for (int i = 0; i < 30; i++) tick();
        check_outs("no_timeout", 1'b0, 1'b0, 1'b0, 8'd0);
        key_in = 3'b010;
        tick();
        check_outs("late_press", 1'b1, 1'b0, 1'b0, 8'd1);
        key_in = 3'b000;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
